// File: rtl/lmdpl_pkg.sv
// rtl/lmdpl_pkg.sv - shared phase encoding and dual-rail helpers for the LMDPL register pipeline
package lmdpl_pkg;

    localparam int MAX_W = 64;

    typedef enum logic {
        PH_PRE  = 1'b0,
        PH_EVAL = 1'b1
    } phase_e;

    // Callers truncate the result to their own rail width.
    function automatic logic [MAX_W-1:0] spacer(input logic precharge, input int width);
        logic [MAX_W-1:0] mask;
        mask = (width >= MAX_W) ? {MAX_W{1'b1}} : ((64'd1 << width) - 64'd1);
        return {MAX_W{precharge}} & mask;
    endfunction

    function automatic logic [MAX_W-1:0] dr_valid(input logic [MAX_W-1:0] t,
                                                  input logic [MAX_W-1:0] f);
        return t ^ f;
    endfunction

endpackage

// File: rtl/lmdpl_dr_stage.sv
// rtl/lmdpl_dr_stage.sv - one WIDTH-bit dual-rail register stage with data/spacer tag
module lmdpl_dr_stage
    import lmdpl_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter bit PRECHARGE = 1'b0
) (
    input  logic             C,
    input  logic             R,
    input  logic             EN,
    input  logic [WIDTH-1:0] i_t,
    input  logic [WIDTH-1:0] i_f,
    input  logic             i_tag,
    output logic [WIDTH-1:0] o_t,
    output logic [WIDTH-1:0] o_f,
    output logic             o_tag
);

    localparam logic [WIDTH-1:0] SPC = WIDTH'(spacer(PRECHARGE, WIDTH));

    logic [WIDTH-1:0] r_t;
    logic [WIDTH-1:0] r_f;
    logic             r_tag;

    always_ff @(posedge C) begin
        if (R) begin
            r_t   <= SPC;
            r_f   <= SPC;
            r_tag <= 1'b0;
        end else if (EN) begin
            r_t   <= i_t;
            r_f   <= i_f;
            r_tag <= i_tag;
        end
    end

    assign o_t   = r_t;
    assign o_f   = r_f;
    assign o_tag = r_tag;

endmodule

// File: rtl/lmdpl_dr_pipe.sv
// rtl/lmdpl_dr_pipe.sv - DEPTH-stage dual-rail pipeline with precharge/evaluate phase FSM and sticky code-word check
module lmdpl_dr_pipe
    import lmdpl_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int DEPTH     = 2,
    parameter bit PRECHARGE = 1'b0
) (
    input  logic             C,
    input  logic             R,
    input  logic             EN,
    input  logic [WIDTH-1:0] DT,
    input  logic [WIDTH-1:0] DF,
    output logic [WIDTH-1:0] QT,
    output logic [WIDTH-1:0] QF,
    output logic             VALID,
    output logic             PH,
    output logic             ERR
);

    localparam logic [WIDTH-1:0] SPC = WIDTH'(spacer(PRECHARGE, WIDTH));

    phase_e                      r_phase;
    phase_e                      w_phase_nxt;
    logic                        r_err;
    logic                        w_viol;
    logic [WIDTH-1:0]            w_pair_ok;
    logic [WIDTH-1:0]            w_in_t;
    logic [WIDTH-1:0]            w_in_f;
    logic                        w_in_tag;
    logic [DEPTH:0][WIDTH-1:0]   w_t;
    logic [DEPTH:0][WIDTH-1:0]   w_f;
    logic [DEPTH:0]              w_tag;

    assign w_pair_ok = WIDTH'(dr_valid(MAX_W'(DT), MAX_W'(DF)));

    always_ff @(posedge C) begin
        if (R) begin
            r_phase <= PH_PRE;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // In PRE the inputs only feed the violation check; the spacer is what gets captured.
    always_comb begin
        w_phase_nxt = r_phase;
        w_viol      = 1'b0;
        w_in_t      = SPC;
        w_in_f      = SPC;
        w_in_tag    = 1'b0;
        case (r_phase)
            PH_PRE: begin
                w_viol = (DT != SPC) || (DF != SPC);
                if (EN) w_phase_nxt = PH_EVAL;
            end
            PH_EVAL: begin
                w_in_t   = DT;
                w_in_f   = DF;
                w_in_tag = 1'b1;
                w_viol   = ~&w_pair_ok;
                if (EN) w_phase_nxt = PH_PRE;
            end
            default: w_phase_nxt = PH_PRE;
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            r_err <= 1'b0;
        end else if (EN && w_viol) begin
            r_err <= 1'b1;
        end
    end

    assign w_t[0]   = w_in_t;
    assign w_f[0]   = w_in_f;
    assign w_tag[0] = w_in_tag;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        lmdpl_dr_stage #(
            .WIDTH     (WIDTH),
            .PRECHARGE (PRECHARGE)
        ) u_stage (
            .C     (C),
            .R     (R),
            .EN    (EN),
            .i_t   (w_t[g]),
            .i_f   (w_f[g]),
            .i_tag (w_tag[g]),
            .o_t   (w_t[g+1]),
            .o_f   (w_f[g+1]),
            .o_tag (w_tag[g+1])
        );
    end

    assign QT    = w_t[DEPTH];
    assign QF    = w_f[DEPTH];
    assign VALID = w_tag[DEPTH];
    assign PH    = r_phase;
    assign ERR   = r_err;

endmodule
